// File: rtl/mips_muldiv_ctrl_if.sv
// Pipeline <-> multiply/divide sequencer port bundle: launch, MTHI/MTLO, HI/LO readback and stall.
// master = execute stage side, slave = sequencer side.
interface mips_muldiv_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [1:0]            op;
   logic [DATA_WIDTH-1:0] rs_data;
   logic [DATA_WIDTH-1:0] rt_data;
   logic                  hi_we;
   logic                  lo_we;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  rd_hilo;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;
   logic                  busy;
   logic                  done;
   logic                  stall_req;

   modport master (
      output start, op, rs_data, rt_data, hi_we, lo_we, wdata, rd_hilo,
      input  hi, lo, busy, done, stall_req
   );

   modport slave (
      input  start, op, rs_data, rt_data, hi_we, lo_we, wdata, rd_hilo,
      output hi, lo, busy, done, stall_req
   );
endinterface

// File: rtl/mips_muldiv_ctrl.sv
// Iterative MULT/DIV sequencer owning HI/LO; MULDIV_UNSIGNED_EN enables MULTU/DIVU via op[1].
// Latency: start edge to HI/LO valid = 33 cycles (32 iterations + sign fix), busy for those 33 cycles.
// Backpressure: no accept handshake; while busy, any HI/LO access or new start raises stall_req.
module mips_muldiv_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 5
) (
   input logic               clk,
   input logic               rst,
   mips_muldiv_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]              state;
   logic [CNT_WIDTH-1:0]    count;
   logic [2*DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0]   m;
   logic [DATA_WIDTH-1:0]   hi_q;
   logic [DATA_WIDTH-1:0]   lo_q;
   logic                    op_div;
   logic                    sign_a;
   logic                    sign_b;
   logic                    div0;
   logic                    done_q;
   logic                    busy_w;

   logic                    signed_op;
`ifdef MULDIV_UNSIGNED_EN
   assign signed_op = ~bus.op[1];
`else
   logic unused_op_hi;
   assign signed_op    = 1'b1;
   assign unused_op_hi = bus.op[1];
`endif

   logic                  in_sign_a;
   logic                  in_sign_b;
   logic [DATA_WIDTH-1:0] mag_a;
   logic [DATA_WIDTH-1:0] mag_b;

   assign in_sign_a = signed_op & bus.rs_data[DATA_WIDTH-1];
   assign in_sign_b = signed_op & bus.rt_data[DATA_WIDTH-1];
   assign mag_a     = in_sign_a ? -bus.rs_data : bus.rs_data;
   assign mag_b     = in_sign_b ? -bus.rt_data : bus.rt_data;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
   // Divide:   acc = {remainder, dividend/quotient bits}, shifted left each step.
   logic [DATA_WIDTH:0]   mul_sum;
   logic [DATA_WIDTH:0]   rem_sh;
   logic [DATA_WIDTH-1:0] div_diff;
   logic                  div_ge;

   assign mul_sum  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, m};
   assign rem_sh   = acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
   assign div_ge   = rem_sh >= {1'b0, m};
   // When div_ge holds the true difference is below m, so the low bits are exact.
   assign div_diff = rem_sh[DATA_WIDTH-1:0] - m;

   logic [2*DATA_WIDTH-1:0] prod_fix;
   logic [DATA_WIDTH-1:0]   quot_fix;
   logic [DATA_WIDTH-1:0]   rem_fix;

   assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
   // Divide-by-zero: remainder path already reproduces rs_data; only LO needs forcing.
   assign quot_fix = div0 ? {DATA_WIDTH{1'b1}}
                   : ((sign_a ^ sign_b) ? -acc[DATA_WIDTH-1:0] : acc[DATA_WIDTH-1:0]);
   assign rem_fix  = sign_a ? -acc[2*DATA_WIDTH-1:DATA_WIDTH] : acc[2*DATA_WIDTH-1:DATA_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         acc    <= '0;
         m      <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         op_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         div0   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state == FIX);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_div <= bus.op[0];
                  sign_a <= in_sign_a;
                  sign_b <= in_sign_b;
                  div0   <= bus.op[0] & (bus.rt_data == '0);
                  m      <= bus.op[0] ? mag_b : mag_a;
                  acc    <= {{DATA_WIDTH{1'b0}}, (bus.op[0] ? mag_a : mag_b)};
                  count  <= '0;
                  state  <= CALC;
               end else begin
                  if (bus.hi_we) hi_q <= bus.wdata;
                  if (bus.lo_we) lo_q <= bus.wdata;
               end
            end
            CALC: begin
               count <= count + 1'b1;
               if (op_div)
                  acc <= div_ge ? {div_diff, acc[DATA_WIDTH-2:0], 1'b1}
                                : {acc[2*DATA_WIDTH-2:0], 1'b0};
               else
                  acc <= acc[0] ? {mul_sum, acc[DATA_WIDTH-1:1]}
                                : {1'b0, acc[2*DATA_WIDTH-1:1]};
               if (count == {CNT_WIDTH{1'b1}}) state <= FIX;
            end
            FIX: begin
               if (op_div) begin
                  hi_q <= rem_fix;
                  lo_q <= quot_fix;
               end else begin
                  hi_q <= prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
                  lo_q <= prod_fix[DATA_WIDTH-1:0];
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_w        = (state != IDLE);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.busy      = busy_w;
   assign bus.done      = done_q;
   assign bus.stall_req = busy_w & (bus.rd_hilo | bus.hi_we | bus.lo_we | bus.start);
endmodule
